// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default field widths and ALU operation-class encodings.
package pipeline_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_REG_W  = 5;

    typedef enum logic [1:0] {
        AluAdd   = 2'b00,
        AluSub   = 2'b01,
        AluFunct = 2'b10,
        AluRsvd  = 2'b11
    } alu_op_e;

endpackage

// File: rtl/id_ex_reg_if.sv
// ID/EX boundary bundle: ID-stage fields in, registered EX-stage copies out.
interface id_ex_reg_if
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_W  = DEF_REG_W
);
    logic              reg_write_id, mem_to_reg_id, mem_read_id, mem_write_id;
    logic              branch_id, alu_src_id, reg_dst_id;
    logic [1:0]        alu_op_id;
    logic [DATA_W-1:0] pc4_id, rs_data_id, rt_data_id, imm_ext_id;
    logic [REG_W-1:0]  rs_id, rt_id, rd_id;

    logic              reg_write_ex, mem_to_reg_ex, mem_read_ex, mem_write_ex;
    logic              branch_ex, alu_src_ex, reg_dst_ex;
    logic [1:0]        alu_op_ex;
    logic [DATA_W-1:0] pc4_ex, rs_data_ex, rt_data_ex, imm_ext_ex;
    logic [REG_W-1:0]  rs_ex, rt_ex, rd_ex;
    logic              valid_ex;

    modport master (
        output reg_write_id, mem_to_reg_id, mem_read_id, mem_write_id,
        output branch_id, alu_src_id, reg_dst_id, alu_op_id,
        output pc4_id, rs_data_id, rt_data_id, imm_ext_id, rs_id, rt_id, rd_id,
        input  reg_write_ex, mem_to_reg_ex, mem_read_ex, mem_write_ex,
        input  branch_ex, alu_src_ex, reg_dst_ex, alu_op_ex,
        input  pc4_ex, rs_data_ex, rt_data_ex, imm_ext_ex, rs_ex, rt_ex, rd_ex, valid_ex
    );

    modport slave (
        input  reg_write_id, mem_to_reg_id, mem_read_id, mem_write_id,
        input  branch_id, alu_src_id, reg_dst_id, alu_op_id,
        input  pc4_id, rs_data_id, rt_data_id, imm_ext_id, rs_id, rt_id, rd_id,
        output reg_write_ex, mem_to_reg_ex, mem_read_ex, mem_write_ex,
        output branch_ex, alu_src_ex, reg_dst_ex, alu_op_ex,
        output pc4_ex, rs_data_ex, rt_data_ex, imm_ext_ex, rs_ex, rt_ex, rd_ex, valid_ex
    );

endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline field register: async active-low reset, synchronous clear over enable.
module pipe_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (en) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall hold, flush-to-bubble and a saturating bubble counter.
module id_ex_reg
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_W  = DEF_REG_W,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    id_ex_reg_if.slave       bus,
    output logic [CNT_W-1:0] bubble_cnt
);

    // Flush is the clear input of every field, so it wins over stall inside pipe_reg.
    logic w_en;
    assign w_en = ~stall;

    pipe_reg #(.WIDTH(1)) u_reg_write (.clk(clk), .rst_n(rst_n), .en(w_en), .clr(flush),
                                       .d(bus.reg_write_id), .q(bus.reg_write_ex));
    pipe_reg #(.WIDTH(1)) u_mem_to_reg (.clk(clk), .rst_n(rst_n), .en(w_en), .clr(flush),
                                        .d(bus.mem_to_reg_id), .q(bus.mem_to_reg_ex));
    pipe_reg #(.WIDTH(1)) u_mem_read (.clk(clk), .rst_n(rst_n), .en(w_en), .clr(flush),
                                      .d(bus.mem_read_id), .q(bus.mem_read_ex));
    pipe_reg #(.WIDTH(1)) u_mem_write (.clk(clk), .rst_n(rst_n), .en(w_en), .clr(flush),
                                       .d(bus.mem_write_id), .q(bus.mem_write_ex));
    pipe_reg #(.WIDTH(1)) u_branch (.clk(clk), .rst_n(rst_n), .en(w_en), .clr(flush),
                                    .d(bus.branch_id), .q(bus.branch_ex));
    pipe_reg #(.WIDTH(1)) u_alu_src (.clk(clk), .rst_n(rst_n), .en(w_en), .clr(flush),
                                     .d(bus.alu_src_id), .q(bus.alu_src_ex));
    pipe_reg #(.WIDTH(1)) u_reg_dst (.clk(clk), .rst_n(rst_n), .en(w_en), .clr(flush),
                                     .d(bus.reg_dst_id), .q(bus.reg_dst_ex));
    pipe_reg #(.WIDTH(2)) u_alu_op (.clk(clk), .rst_n(rst_n), .en(w_en), .clr(flush),
                                    .d(bus.alu_op_id), .q(bus.alu_op_ex));

    pipe_reg #(.WIDTH(DATA_W)) u_pc4 (.clk(clk), .rst_n(rst_n), .en(w_en), .clr(flush),
                                      .d(bus.pc4_id), .q(bus.pc4_ex));
    pipe_reg #(.WIDTH(DATA_W)) u_rs_data (.clk(clk), .rst_n(rst_n), .en(w_en), .clr(flush),
                                          .d(bus.rs_data_id), .q(bus.rs_data_ex));
    pipe_reg #(.WIDTH(DATA_W)) u_rt_data (.clk(clk), .rst_n(rst_n), .en(w_en), .clr(flush),
                                          .d(bus.rt_data_id), .q(bus.rt_data_ex));
    pipe_reg #(.WIDTH(DATA_W)) u_imm_ext (.clk(clk), .rst_n(rst_n), .en(w_en), .clr(flush),
                                          .d(bus.imm_ext_id), .q(bus.imm_ext_ex));

    pipe_reg #(.WIDTH(REG_W)) u_rs (.clk(clk), .rst_n(rst_n), .en(w_en), .clr(flush),
                                    .d(bus.rs_id), .q(bus.rs_ex));
    pipe_reg #(.WIDTH(REG_W)) u_rt (.clk(clk), .rst_n(rst_n), .en(w_en), .clr(flush),
                                    .d(bus.rt_id), .q(bus.rt_ex));
    pipe_reg #(.WIDTH(REG_W)) u_rd (.clk(clk), .rst_n(rst_n), .en(w_en), .clr(flush),
                                    .d(bus.rd_id), .q(bus.rd_ex));

    pipe_reg #(.WIDTH(1)) u_valid (.clk(clk), .rst_n(rst_n), .en(w_en), .clr(flush),
                                   .d(1'b1), .q(bus.valid_ex));

    logic [CNT_W-1:0] r_bubble_cnt;
    logic             w_cnt_sat;
    assign w_cnt_sat = &r_bubble_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (flush && !w_cnt_sat) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: load, stall, flush priority, counter saturation, async reset.
module tb_id_ex_reg;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] bubble_cnt;
    logic [1:0]  bubble_cnt_s;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    id_ex_reg_if #(.DATA_W(32), .REG_W(5)) bus ();
    id_ex_reg_if #(.DATA_W(32), .REG_W(5)) bus_s ();

    id_ex_reg #(.DATA_W(32), .REG_W(5), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .bus(bus),
        .bubble_cnt(bubble_cnt)
    );

    id_ex_reg #(.DATA_W(32), .REG_W(5), .CNT_W(2)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .bus(bus_s),
        .bubble_cnt(bubble_cnt_s)
    );

    // Narrow-counter instance sees identical ID-stage stimulus.
    assign bus_s.reg_write_id  = bus.reg_write_id;
    assign bus_s.mem_to_reg_id = bus.mem_to_reg_id;
    assign bus_s.mem_read_id   = bus.mem_read_id;
    assign bus_s.mem_write_id  = bus.mem_write_id;
    assign bus_s.branch_id     = bus.branch_id;
    assign bus_s.alu_src_id    = bus.alu_src_id;
    assign bus_s.reg_dst_id    = bus.reg_dst_id;
    assign bus_s.alu_op_id     = bus.alu_op_id;
    assign bus_s.pc4_id        = bus.pc4_id;
    assign bus_s.rs_data_id    = bus.rs_data_id;
    assign bus_s.rt_data_id    = bus.rt_data_id;
    assign bus_s.imm_ext_id    = bus.imm_ext_id;
    assign bus_s.rs_id         = bus.rs_id;
    assign bus_s.rt_id         = bus.rt_id;
    assign bus_s.rd_id         = bus.rd_id;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.reg_write_id  = 1'b0;
        bus.mem_to_reg_id = 1'b0;
        bus.mem_read_id   = 1'b0;
        bus.mem_write_id  = 1'b0;
        bus.branch_id     = 1'b0;
        bus.alu_src_id    = 1'b0;
        bus.reg_dst_id    = 1'b0;
        bus.alu_op_id     = AluAdd;
        bus.pc4_id        = '0;
        bus.rs_data_id    = '0;
        bus.rt_data_id    = '0;
        bus.imm_ext_id    = '0;
        bus.rs_id         = '0;
        bus.rt_id         = '0;
        bus.rd_id         = '0;

        // Reset state, with an edge passing while reset is held.
        #12;
        check("rst_imm", bus.imm_ext_ex, 0);
        check("rst_valid", bus.valid_ex, 0);
        check("rst_bubble", bubble_cnt, 0);
        check("rst_rd", bus.rd_ex, 0);
        rst_n = 1'b1;

        // Normal load of every field.
        bus.imm_ext_id    = 32'hFFFF_FFFF;
        bus.rd_id         = 5'd5;
        bus.reg_write_id  = 1'b1;
        bus.mem_to_reg_id = 1'b1;
        bus.mem_write_id  = 1'b1;
        bus.branch_id     = 1'b1;
        bus.alu_src_id    = 1'b1;
        bus.reg_dst_id    = 1'b1;
        bus.alu_op_id     = AluFunct;
        bus.pc4_id        = 32'h0000_0104;
        bus.rs_data_id    = 32'hA5A5_A5A5;
        bus.rt_data_id    = 32'h1234_5678;
        bus.rs_id         = 5'd3;
        bus.rt_id         = 5'd31;
        step();
        check("ld_imm", bus.imm_ext_ex, 64'hFFFF_FFFF);
        check("ld_rd", bus.rd_ex, 5);
        check("ld_reg_write", bus.reg_write_ex, 1);
        check("ld_valid", bus.valid_ex, 1);
        check("ld_mem_to_reg", bus.mem_to_reg_ex, 1);
        check("ld_mem_read", bus.mem_read_ex, 0);
        check("ld_mem_write", bus.mem_write_ex, 1);
        check("ld_branch", bus.branch_ex, 1);
        check("ld_alu_src", bus.alu_src_ex, 1);
        check("ld_reg_dst", bus.reg_dst_ex, 1);
        check("ld_alu_op", bus.alu_op_ex, 2'b10);
        check("ld_pc4", bus.pc4_ex, 64'h104);
        check("ld_rs_data", bus.rs_data_ex, 64'hA5A5_A5A5);
        check("ld_rt_data", bus.rt_data_ex, 64'h1234_5678);
        check("ld_rs", bus.rs_ex, 3);
        check("ld_rt", bus.rt_ex, 31);
        check("ld_bubble", bubble_cnt, 0);

        // Stall for three edges holds everything.
        bus.imm_ext_id = 32'h0000_0001;
        bus.rd_id      = 5'd9;
        stall          = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_imm", bus.imm_ext_ex, 64'hFFFF_FFFF);
            check("stall_rd", bus.rd_ex, 5);
            check("stall_valid", bus.valid_ex, 1);
            check("stall_bubble", bubble_cnt, 0);
        end
        stall = 1'b0;
        step();
        check("unstall_imm", bus.imm_ext_ex, 64'h1);
        check("unstall_rd", bus.rd_ex, 9);

        // Flush beats stall on the same edge.
        bus.mem_read_id = 1'b1;
        flush           = 1'b1;
        stall           = 1'b1;
        step();
        check("fl_mem_read", bus.mem_read_ex, 0);
        check("fl_valid", bus.valid_ex, 0);
        check("fl_bubble", bubble_cnt, 1);
        check("fl_bubble_s", bubble_cnt_s, 1);
        check("fl_imm", bus.imm_ext_ex, 0);
        check("fl_pc4", bus.pc4_ex, 0);
        check("fl_reg_write", bus.reg_write_ex, 0);
        check("fl_alu_op", bus.alu_op_ex, 0);
        check("fl_rs", bus.rs_ex, 0);
        flush = 1'b0;
        stall = 1'b0;
        step();
        check("reload_valid", bus.valid_ex, 1);
        check("reload_mem_read", bus.mem_read_ex, 1);
        check("reload_bubble", bubble_cnt, 1);

        // Asynchronous reset between edges while valid.
        rst_n = 1'b0;
        #2;
        check("arst_valid", bus.valid_ex, 0);
        check("arst_imm", bus.imm_ext_ex, 0);
        check("arst_reg_write", bus.reg_write_ex, 0);
        check("arst_bubble", bubble_cnt, 0);
        check("arst_bubble_s", bubble_cnt_s, 0);
        rst_n = 1'b1;

        // Four back-to-back flushes; 2-bit counter saturates at 3.
        flush = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("fl4_valid", bus.valid_ex, 0);
            check("fl4_bubble", bubble_cnt, 64'(i));
            check("fl4_bubble_s", bubble_cnt_s, (i > 3) ? 64'd3 : 64'(i));
        end
        step();
        check("sat_hold_s", bubble_cnt_s, 3);
        check("fl5_bubble", bubble_cnt, 5);
        flush = 1'b0;

        // Reset mid-stall-and-flush, then a clean load on the first edge after release.
        stall = 1'b1;
        flush = 1'b1;
        #2;
        rst_n = 1'b0;
        #2;
        check("rst_mid_bubble", bubble_cnt, 0);
        check("rst_mid_valid", bus.valid_ex, 0);
        rst_n = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        bus.imm_ext_id = 32'h8000_0000;
        bus.rd_id      = 5'd17;
        step();
        check("post_rst_imm", bus.imm_ext_ex, 64'h8000_0000);
        check("post_rst_rd", bus.rd_ex, 17);
        check("post_rst_valid", bus.valid_ex, 1);
        check("post_rst_bubble", bubble_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
